axi_burst_addr_gen: RTL and testbench
=====================================

AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum beats per burst.
REQ-003 SHALL have port aclk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port transfer  input  1  request strobe, sampled only while ready=1.
REQ-006 SHALL have port start_addr  input  ADDR_W  first-beat byte address.
REQ-007 SHALL have port btyp  input  2  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-008 SHALL have port blen  input  5  beats per burst, 1..MAX_LEN.
REQ-009 SHALL have port bsize  input  4  bytes per beat; legal values are 1, 2, 4 and 8.
REQ-010 SHALL have port ready  output  1  block is idle and accepts a request.
REQ-011 SHALL have port beat_valid  output  1  beat_addr, beat_idx and beat_last are valid.
REQ-012 SHALL have port beat_ready  input  1  downstream accepts the current beat.
REQ-013 SHALL have port beat_addr  output  ADDR_W  byte address of the current beat.
REQ-014 SHALL have port beat_idx  output  4  zero-based index of the current beat.
REQ-015 SHALL have port beat_last  output  1  the current beat is the final beat.
REQ-016 SHALL have port err  output  1  one-cycle pulse flagging an illegal request.

Function
REQ-017 SHALL implement FSM states IDLE and BURST; ready=1 exactly in IDLE.
REQ-018 IDLE with transfer=1 and a legal request SHALL latch all request inputs, enter BURST, and assert beat_valid with beat_addr=start_addr and beat_idx=0 on the next cycle.
REQ-019 A request SHALL be illegal if any holds: btyp=3; bsize not in {1,2,4,8}; blen=0 or blen>MAX_LEN; WRAP with blen not in {2,4,8,16}; start_addr not a multiple of bsize; INCR with start_addr[11:0] + blen*bsize > 4096 (crosses 4 KB).
REQ-020 An illegal request SHALL pulse err for exactly one cycle on the next cycle, keep the FSM in IDLE, and leave beat_valid=0.
REQ-021 transfer SHALL be ignored while in BURST.
REQ-022 A beat SHALL complete on any cycle where beat_valid=1 and beat_ready=1.
REQ-023 While beat_valid=1 and beat_ready=0, beat_addr, beat_idx and beat_last SHALL hold stable.
REQ-024 FIXED: every beat address SHALL equal start_addr.
REQ-025 INCR: each next address SHALL be the previous address plus bsize, computed at ADDR_W bits.
REQ-026 WRAP: with W=blen*bsize and lower bound LB = start_addr rounded down to a multiple of W, next = addr+bsize; if next = LB+W, next SHALL be LB.
REQ-027 beat_idx SHALL increment by 1 on each completed beat; beat_last SHALL be 1 exactly when beat_idx = latched blen-1.
REQ-028 On completion of the last beat, the FSM SHALL enter IDLE, with beat_valid=0 and ready=1 on the following cycle.
REQ-029 A new request SHALL be accepted no earlier than the cycle after ready returns to 1, giving at least one idle cycle between bursts.
REQ-030 The WRAP bound SHALL be computed using shifts only, since W is a power of two; no divider SHALL be used.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE, ready=1, beat_valid=0, beat_addr=0, beat_idx=0, beat_last=0 and err=0, including mid-burst.
REQ-032 After reset deasserts, the first accepted request SHALL behave exactly as it would after power-up, with no residual state.

Verification
REQ-033 INCR test: start_addr=0x10, bsize=4, blen=4, beat_ready=1 -> beat_addr 0x10, 0x14, 0x18, 0x1C; beat_last set on the 4th beat; ready=1 the cycle after.
REQ-034 WRAP test: start_addr=0x38, bsize=4, blen=4 -> beat_addr 0x38, 0x3C, 0x30, 0x34; beat_last set on the beat at 0x34.
REQ-035 FIXED test: start_addr=0x100, bsize=4, blen=8 -> eight beats, all at 0x100, with beat_idx 0..7.
REQ-036 Backpressure test: INCR start_addr=0x0, bsize=4, blen=4; beat_ready=0 for 3 cycles at beat 1 -> beat_addr=0x4 and beat_idx=1 held stable; burst completes with 4 beats total.
REQ-037 Illegal-request tests: WRAP blen=12, start_addr=0x02 with bsize=4, and INCR start_addr=0xFF8 with bsize=4, blen=4 -> each gives a 1-cycle err pulse, ready stays 1, and beat_valid stays 0.
REQ-038 Reset test: reset asserted after beat 2 of an 8-beat INCR burst -> beat_valid=0 immediately; a subsequent legal request restarts at beat_idx=0.

Source files
------------

// File: rtl/axi_burst_addr_gen_if.sv
// Request and beat handshake bundle for the AXI burst address generator.
// The slave modport is the generator side; master is the requester/consumer side.
interface axi_burst_addr_gen_if #(
  parameter int ADDR_W = 32
);
  logic              transfer;
  logic [ADDR_W-1:0] start_addr;
  logic [1:0]        btyp;
  logic [4:0]        blen;
  logic [3:0]        bsize;
  logic              ready;
  logic              beat_valid;
  logic              beat_ready;
  logic [ADDR_W-1:0] beat_addr;
  logic [3:0]        beat_idx;
  logic              beat_last;
  logic              err;

  modport slave (
    input  transfer, start_addr, btyp, blen, bsize, beat_ready,
    output ready, beat_valid, beat_addr, beat_idx, beat_last, err
  );

  modport master (
    output transfer, start_addr, btyp, blen, bsize, beat_ready,
    input  ready, beat_valid, beat_addr, beat_idx, beat_last, err
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: accepts a burst request while idle, validates
// it, then emits one address per beat (FIXED / INCR / WRAP) under a
// valid/ready handshake. Illegal requests produce a one-cycle err pulse.
module axi_burst_addr_gen #(
  parameter int ADDR_W  = 32,
  parameter int MAX_LEN = 16
) (
  input logic                aclk,
  input logic                reset,
  axi_burst_addr_gen_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [1:0] T_FIXED = 2'd0;
  localparam logic [1:0] T_INCR  = 2'd1;
  localparam logic [1:0] T_WRAP  = 2'd2;
  localparam logic [1:0] T_RSVD  = 2'd3;

  localparam logic [5:0] MAX_LEN_V = 6'(MAX_LEN);

  logic [0:0]        state;
  logic [1:0]        typ_q;
  logic [4:0]        len_q;
  logic [3:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] lb_q;
  logic [ADDR_W-1:0] wrap_end_q;
  logic [3:0]        idx_q;
  logic              last_q;
  logic              err_q;

  // Request decode signals
  logic [1:0]        sz_sh;
  logic              size_ok;
  logic [2:0]        len_sh;
  logic              len_pow2;
  logic              len_ok;
  logic              align_ok;
  logic [13:0]       span;
  logic              cross_4k;
  logic              illegal;
  logic [2:0]        wrap_sh;
  logic [ADDR_W-1:0] wrap_lb;
  logic [ADDR_W-1:0] wrap_end;

  // Beat advance signals
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_nxt;
  logic              beat_done;

  // Decode bsize to a shift amount; only 1/2/4/8 are legal
  always_comb begin
    sz_sh   = 2'd0;
    size_ok = 1'b1;
    case (bus.bsize)
      4'd1:    sz_sh = 2'd0;
      4'd2:    sz_sh = 2'd1;
      4'd4:    sz_sh = 2'd2;
      4'd8:    sz_sh = 2'd3;
      default: size_ok = 1'b0;
    endcase
  end

  // Decode blen to a shift amount for wrap bursts (power-of-two lengths only)
  always_comb begin
    len_sh   = 3'd0;
    len_pow2 = 1'b1;
    case (bus.blen)
      5'd2:    len_sh = 3'd1;
      5'd4:    len_sh = 3'd2;
      5'd8:    len_sh = 3'd3;
      5'd16:   len_sh = 3'd4;
      default: len_pow2 = 1'b0;
    endcase
  end

  // Legality checks and wrap window computed with shifts (W is a power of two)
  always_comb begin
    len_ok   = (bus.blen != 5'd0) && ({1'b0, bus.blen} <= MAX_LEN_V);
    align_ok = (bus.start_addr[3:0] & (bus.bsize - 4'd1)) == 4'd0;
    span     = {2'b00, bus.start_addr[11:0]} + ({9'd0, bus.blen} << sz_sh);
    cross_4k = span > 14'd4096;
    illegal  = (bus.btyp == T_RSVD)
            || !size_ok
            || !len_ok
            || ((bus.btyp == T_WRAP) && !len_pow2)
            || !align_ok
            || ((bus.btyp == T_INCR) && cross_4k);
    wrap_sh  = 3'(sz_sh) + len_sh;
    wrap_lb  = (bus.start_addr >> wrap_sh) << wrap_sh;
    wrap_end = wrap_lb + (ADDR_W'(1) << wrap_sh);
  end

  // Next beat address by burst type
  always_comb begin
    addr_inc = addr_q + ADDR_W'(size_q);
    addr_nxt = addr_inc;
    case (typ_q)
      T_FIXED: addr_nxt = addr_q;
      T_WRAP:  addr_nxt = (addr_inc == wrap_end_q) ? lb_q : addr_inc;
      default: addr_nxt = addr_inc;
    endcase
    beat_done = (state == BURST) && bus.beat_ready;
  end

  // Burst FSM: accept/reject requests in IDLE, step beats in BURST
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      typ_q      <= '0;
      len_q      <= '0;
      size_q     <= '0;
      addr_q     <= '0;
      lb_q       <= '0;
      wrap_end_q <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.transfer) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              typ_q      <= bus.btyp;
              len_q      <= bus.blen;
              size_q     <= bus.bsize;
              addr_q     <= bus.start_addr;
              lb_q       <= wrap_lb;
              wrap_end_q <= wrap_end;
              idx_q      <= '0;
              last_q     <= (bus.blen == 5'd1);
              state      <= BURST;
            end
          end
        end
        BURST: begin
          if (beat_done) begin
            if (last_q) begin
              state  <= IDLE;
              idx_q  <= '0;
              last_q <= 1'b0;
            end else begin
              addr_q <= addr_nxt;
              idx_q  <= idx_q + 4'd1;
              // idx+1 becomes the final beat when idx+2 equals the length
              last_q <= ((5'(idx_q) + 5'd2) == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready      = (state == IDLE);
  assign bus.beat_valid = (state == BURST);
  assign bus.beat_addr  = addr_q;
  assign bus.beat_idx   = idx_q;
  assign bus.beat_last  = last_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed self-checking bench for axi_burst_addr_gen.
module tb_axi_burst_addr_gen;

  logic aclk = 1'b0;
  logic reset;

  always #5 aclk = ~aclk;

  axi_burst_addr_gen_if #(.ADDR_W(32)) bus ();

  axi_burst_addr_gen #(.ADDR_W(32), .MAX_LEN(16)) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic request(input logic [31:0] a, input logic [1:0] t,
                         input logic [4:0] l, input logic [3:0] s);
    bus.transfer   = 1'b1;
    bus.start_addr = a;
    bus.btyp       = t;
    bus.blen       = l;
    bus.bsize      = s;
    tick();
    bus.transfer   = 1'b0;
  endtask

  // Walk the beats listed in exp_q; optional stall at one beat and optional
  // transfer held high mid-burst (must be ignored).
  task automatic run_burst(input string tag, input int stall_beat,
                           input int stall_cycles, input bit hold_xfer);
    int n;
    n = exp_q.size();
    if (hold_xfer) bus.start_addr = 32'h999;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 64'(bus.beat_valid), 64'd1);
      check($sformatf("%s_ready%0d", tag, i), 64'(bus.ready), 64'd0);
      check($sformatf("%s_addr%0d", tag, i), 64'(bus.beat_addr), 64'(exp_q[i]));
      check($sformatf("%s_idx%0d", tag, i), 64'(bus.beat_idx), 64'(i));
      check($sformatf("%s_last%0d", tag, i), 64'(bus.beat_last), 64'(i == n - 1));
      if (i == stall_beat) begin
        bus.beat_ready = 1'b0;
        for (int c = 0; c < stall_cycles; c++) begin
          tick();
          check($sformatf("%s_hold_valid%0d", tag, c), 64'(bus.beat_valid), 64'd1);
          check($sformatf("%s_hold_addr%0d", tag, c), 64'(bus.beat_addr), 64'(exp_q[i]));
          check($sformatf("%s_hold_idx%0d", tag, c), 64'(bus.beat_idx), 64'(i));
          check($sformatf("%s_hold_last%0d", tag, c), 64'(bus.beat_last), 64'(i == n - 1));
        end
        bus.beat_ready = 1'b1;
      end
      bus.transfer = hold_xfer && (i != n - 1);
      tick();
    end
    bus.transfer = 1'b0;
    check({tag, "_end_valid"}, 64'(bus.beat_valid), 64'd0);
    check({tag, "_end_ready"}, 64'(bus.ready), 64'd1);
  endtask

  task automatic illegal_req(input string tag, input logic [31:0] a, input logic [1:0] t,
                             input logic [4:0] l, input logic [3:0] s);
    request(a, t, l, s);
    check({tag, "_err"}, 64'(bus.err), 64'd1);
    check({tag, "_ready"}, 64'(bus.ready), 64'd1);
    check({tag, "_valid"}, 64'(bus.beat_valid), 64'd0);
    tick();
    check({tag, "_err_clr"}, 64'(bus.err), 64'd0);
    check({tag, "_ready2"}, 64'(bus.ready), 64'd1);
    check({tag, "_valid2"}, 64'(bus.beat_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.transfer   = 1'b0;
    bus.start_addr = '0;
    bus.btyp       = '0;
    bus.blen       = '0;
    bus.bsize      = '0;
    bus.beat_ready = 1'b1;
    tick();
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_valid", 64'(bus.beat_valid), 64'd0);
    check("rst_addr", 64'(bus.beat_addr), 64'd0);
    check("rst_idx", 64'(bus.beat_idx), 64'd0);
    check("rst_last", 64'(bus.beat_last), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // INCR 0x10, 4 x 4 bytes
    request(32'h10, 2'd1, 5'd4, 4'd4);
    exp_q = '{32'h10, 32'h14, 32'h18, 32'h1C};
    run_burst("incr", -1, 0, 1'b0);

    // WRAP 0x38, 4 x 4 bytes, window 0x30..0x3F
    request(32'h38, 2'd2, 5'd4, 4'd4);
    exp_q = '{32'h38, 32'h3C, 32'h30, 32'h34};
    run_burst("wrap", -1, 0, 1'b0);

    // WRAP 0x18, 2 x 8 bytes, window 0x10..0x1F
    request(32'h18, 2'd2, 5'd2, 4'd8);
    exp_q = '{32'h18, 32'h10};
    run_burst("wrap2", -1, 0, 1'b0);

    // FIXED 0x100, 8 beats; transfer held high mid-burst must be ignored
    request(32'h100, 2'd0, 5'd8, 4'd4);
    exp_q = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100};
    run_burst("fixed", -1, 0, 1'b1);
    tick();
    check("fixed_no_reaccept", 64'(bus.beat_valid), 64'd0);

    // Backpressure at beat 1 for 3 cycles
    request(32'h0, 2'd1, 5'd4, 4'd4);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    run_burst("bp", 1, 3, 1'b0);

    // Single-beat burst
    request(32'h7, 2'd1, 5'd1, 4'd1);
    exp_q = '{32'h7};
    run_burst("single", -1, 0, 1'b0);

    // INCR ending exactly on the 4 KB boundary is legal
    request(32'hFF0, 2'd1, 5'd4, 4'd4);
    exp_q = '{32'hFF0, 32'hFF4, 32'hFF8, 32'hFFC};
    run_burst("edge4k", -1, 0, 1'b0);

    // Illegal requests
    illegal_req("ill_wrap12", 32'h0, 2'd2, 5'd12, 4'd4);
    illegal_req("ill_align", 32'h2, 2'd1, 5'd4, 4'd4);
    illegal_req("ill_4k", 32'hFF8, 2'd1, 5'd4, 4'd4);
    illegal_req("ill_rsvd", 32'h0, 2'd3, 5'd4, 4'd4);
    illegal_req("ill_size3", 32'h0, 2'd1, 5'd4, 4'd3);
    illegal_req("ill_len0", 32'h0, 2'd1, 5'd0, 4'd4);
    illegal_req("ill_len17", 32'h0, 2'd0, 5'd17, 4'd4);

    // Reset mid-burst after beat 2 of an 8-beat INCR
    request(32'h200, 2'd1, 5'd8, 4'd4);
    check("mid_addr0", 64'(bus.beat_addr), 64'h200);
    tick();
    check("mid_addr1", 64'(bus.beat_addr), 64'h204);
    tick();
    check("mid_addr2", 64'(bus.beat_addr), 64'h208);
    check("mid_idx2", 64'(bus.beat_idx), 64'd2);
    bus.beat_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.beat_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.ready), 64'd1);
    check("mid_rst_addr", 64'(bus.beat_addr), 64'd0);
    check("mid_rst_idx", 64'(bus.beat_idx), 64'd0);
    check("mid_rst_last", 64'(bus.beat_last), 64'd0);
    check("mid_rst_err", 64'(bus.err), 64'd0);
    tick();
    reset          = 1'b0;
    bus.beat_ready = 1'b1;
    tick();
    request(32'h40, 2'd1, 5'd2, 4'd8);
    exp_q = '{32'h40, 32'h48};
    run_burst("post_rst", -1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
